// File: rtl/lcd_cmd_seq_pkg.sv
// Shared command codes and sequencer state encoding for the LCD command sequencer.
package lcd_cmd_seq_pkg;

    localparam logic [2:0] CMD_DISPLAY  = 3'd0;
    localparam logic [2:0] CMD_LOAD     = 3'd1;
    localparam logic [2:0] CMD_ZOOM_IN  = 3'd2;
    localparam logic [2:0] CMD_ZOOM_FIT = 3'd3;
    localparam logic [2:0] CMD_RIGHT    = 3'd4;
    localparam logic [2:0] CMD_LEFT     = 3'd5;
    localparam logic [2:0] CMD_UP       = 3'd6;
    localparam logic [2:0] CMD_DOWN     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_STREAM  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WAIT_LO = 3'd5
    } seq_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO holding host command codes; head word is visible combinationally.
module lcd_cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_s;
    logic             pop_s;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        if (ptr == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return ptr + AW'(1);
        end
    endfunction

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (count_r == DEPTH_CNT);
    assign empty  = (count_r == {(AW + 1){1'b0}});
    assign dout   = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Queues host commands, gathers LOAD pixel bursts, and issues them to an LCD
// controller with a busy handshake and a sticky timeout error.
module lcd_cmd_seq
    import lcd_cmd_seq_pkg::*;
#(
    parameter int NPIX   = 64,
    parameter int QDEPTH = 4,
    parameter int TMO    = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_cmd_valid,
    output logic       host_cmd_ready,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    output logic       seq_idle,
    output logic       err
);
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW = $clog2(TMO + 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
    localparam logic [CW-1:0] TMO_PRE  = CW'(TMO - 1);
    localparam logic [CW-1:0] TMO_MAX  = CW'(TMO);

    seq_state_e    state_r;
    logic [PW-1:0] wr_idx_r;
    logic [PW-1:0] rd_idx_r;
    logic [CW-1:0] wait_cnt_r;
    logic [7:0]    pix_buf_r [NPIX];

    logic [2:0]    q_head_s;
    logic          q_full_s;
    logic          q_empty_s;
    logic          q_pop_s;
    logic          fill_we_s;

    lcd_cmd_fifo #(
        .WIDTH (3),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (host_cmd_valid),
        .din   (host_cmd),
        .pop   (q_pop_s),
        .dout  (q_head_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    assign host_cmd_ready = !q_full_s;
    assign seq_idle       = (state_r == ST_IDLE) && q_empty_s;
    assign q_pop_s        = (state_r == ST_IDLE) && !q_empty_s;
    // pix_ready is registered high exactly while in FILL, so it doubles as the accept qualifier.
    assign fill_we_s      = pix_ready && pix_valid;

    // Pixel burst buffer; overwritten by each new burst, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            pix_buf_r[wr_idx_r] <= pix_in;
        end
    end

    // Sequencer FSM with all controller-facing outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wr_idx_r   <= {PW{1'b0}};
            rd_idx_r   <= {PW{1'b0}};
            wait_cnt_r <= {CW{1'b0}};
            cmd        <= 3'd0;
            cmd_valid  <= 1'b0;
            datain     <= 8'd0;
            pix_ready  <= 1'b0;
            err        <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            datain    <= 8'd0;
            case (state_r)
                ST_IDLE: begin
                    if (!q_empty_s) begin
                        cmd        <= q_head_s;
                        wait_cnt_r <= {CW{1'b0}};
                        if (q_head_s == CMD_LOAD) begin
                            state_r   <= ST_FILL;
                            wr_idx_r  <= {PW{1'b0}};
                            pix_ready <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        cmd <= cmd;
                    end
                end
                ST_FILL: begin
                    if (pix_valid) begin
                        if (wr_idx_r == LAST_PIX) begin
                            state_r   <= ST_ISSUE;
                            pix_ready <= 1'b0;
                        end else begin
                            wr_idx_r <= wr_idx_r + PW'(1);
                        end
                    end else begin
                        wr_idx_r <= wr_idx_r;
                    end
                end
                ST_ISSUE: begin
                    if (!busy) begin
                        cmd_valid  <= 1'b1;
                        wait_cnt_r <= {CW{1'b0}};
                        if (cmd == CMD_LOAD) begin
                            state_r  <= ST_STREAM;
                            rd_idx_r <= {PW{1'b0}};
                        end else begin
                            state_r <= ST_WAIT_HI;
                        end
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_STREAM: begin
                    datain <= pix_buf_r[rd_idx_r];
                    if (rd_idx_r == LAST_PIX) begin
                        state_r    <= ST_WAIT_LO;
                        wait_cnt_r <= {CW{1'b0}};
                    end else begin
                        rd_idx_r <= rd_idx_r + PW'(1);
                    end
                end
                ST_WAIT_HI: begin
                    if (busy) begin
                        state_r    <= ST_WAIT_LO;
                        wait_cnt_r <= {CW{1'b0}};
                    end else if (wait_cnt_r >= TMO_PRE) begin
                        wait_cnt_r <= TMO_MAX;
                        err        <= 1'b1;
                        state_r    <= ST_IDLE;
                        cmd        <= 3'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!busy) begin
                        state_r <= ST_IDLE;
                        cmd     <= 3'd0;
                    end else if (wait_cnt_r >= TMO_PRE) begin
                        wait_cnt_r <= TMO_MAX;
                        err        <= 1'b1;
                        state_r    <= ST_IDLE;
                        cmd        <= 3'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have parameter NPIX, default 64: pixels per LOAD burst.
REQ-002 SHALL have parameter QDEPTH, default 4: host command queue depth.
REQ-003 SHALL have parameter TMO, default 1023: max cycles spent waiting on busy before error.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port host_cmd, input, 3: command code. 0 display, 1 load, 2 zoom-in, 3 zoom-fit, 4 right, 5 left, 6 up, 7 down.
REQ-007 SHALL have port host_cmd_valid, input, 1: host command offered.
REQ-008 SHALL have port host_cmd_ready, output, 1: queue not full.
REQ-009 SHALL have port pix_in, input, 8: host pixel byte.
REQ-010 SHALL have port pix_valid, input, 1: pixel offered.
REQ-011 SHALL have port pix_ready, output, 1: pixel accepted this cycle when pix_valid=1.
REQ-012 SHALL have port cmd, output, 3: command to the LCD controller.
REQ-013 SHALL have port cmd_valid, output, 1: one-cycle command strobe.
REQ-014 SHALL have port datain, output, 8: pixel stream to the controller.
REQ-015 SHALL have port busy, input, 1: controller busy.
REQ-016 SHALL have port seq_idle, output, 1: FSM in IDLE and queue empty.
REQ-017 SHALL have port err, output, 1: sticky busy-timeout flag.

Function
REQ-018 SHALL push host_cmd into the QDEPTH-entry FIFO when host_cmd_valid and host_cmd_ready are both 1; host_cmd_ready = !full.
REQ-019 SHALL use FSM states IDLE, FILL, ISSUE, STREAM, WAIT_HI, WAIT_LO.
REQ-020 IDLE: with queue non-empty, SHALL pop the head and go to FILL if the code is 1, otherwise to ISSUE; a push to an empty queue SHALL be popped no earlier than the next cycle.
REQ-021 FILL: pix_ready=1 only in this state; SHALL write accepted pixels to buf[wr_idx] with wr_idx 0..NPIX-1, then go to ISSUE on the NPIX-th accept.
REQ-022 ISSUE: SHALL drive cmd_valid=1 for exactly one cycle, and only in a cycle where busy=0; while busy=1 it SHALL hold with cmd_valid=0.
REQ-023 After a load is issued in cycle C, SHALL drive datain=buf[k] in cycle C+1+k for k=0..NPIX-1 (state STREAM), then go to WAIT_LO.
REQ-024 After a non-load command is issued, SHALL go to WAIT_HI; when busy=1, SHALL go to WAIT_LO.
REQ-025 WAIT_LO: when busy=0, SHALL return to IDLE; no new cmd_valid before busy has fallen.
REQ-026 The wait counter SHALL clear on entry to WAIT_HI or WAIT_LO; if it reaches TMO, SHALL set err=1 (sticky until reset) and go to IDLE.
REQ-027 cmd SHALL hold the issued code from ISSUE until return to IDLE.
REQ-028 datain SHALL be 0 outside STREAM.
REQ-029 cmd_valid SHALL never be 1 on two consecutive cycles.
REQ-030 pix_valid outside FILL SHALL be ignored, and no pixel consumed.
REQ-031 Pixel index and wait counters SHALL not wrap: stop at NPIX-1 and TMO respectively.

Reset
REQ-032 reset=0 SHALL asynchronously force: FSM=IDLE, queue empty, counters 0, cmd=0, cmd_valid=0, datain=0, pix_ready=0, err=0; consequently host_cmd_ready=1 and seq_idle=1.
REQ-033 Reset mid-FILL or mid-STREAM SHALL discard the partial burst; buf contents need no reset.

Structure
REQ-034 A shared package SHALL hold the 3-bit command-code constants (CMD_DISPLAY..CMD_DOWN) and the FSM state enum.
REQ-035 The command queue SHALL be a sub-module lcd_cmd_fifo (parameterised width/depth, full/empty flags); the pixel buffer and FSM SHALL stay in lcd_cmd_seq.

Verification
REQ-036 Reset, push cmd 2, model busy high 1 cycle after cmd_valid for 17 cycles -> exactly one cmd_valid with cmd=2; seq_idle=1 after busy falls.
REQ-037 Push cmd 1, feed pixels 0x00..0x3F with random pix_valid gaps -> cmd_valid once after the 64th accept; datain = 0x00..0x3F on the 64 cycles following it; controller model memory matches.
REQ-038 Push 5 commands back-to-back with busy held high -> host_cmd_ready=0 after 4 queued (1 popped into ISSUE); no cmd_valid while busy=1.
REQ-039 Push cmd 4, busy never rises -> err=1 after 1023 cycles in WAIT_HI; FSM returns to IDLE; err stays 1.
REQ-040 Assert reset=0 at the 30th pixel of a load -> all outputs at reset values immediately; a subsequent load with 64 new pixels streams only new data.
